// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronised input, edge-triggered start detect,
// mid-bit sampling timed by a per-bit cycle counter.
`ifndef ICE_STICK_CLOCK_RATE
`define ICE_STICK_CLOCK_RATE 12000000
`endif

module uart_rx #(
  parameter int clockRate = `ICE_STICK_CLOCK_RATE,
  parameter int baudRate  = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_error,
  output logic       busy
);
  localparam int BAUD = clockRate / baudRate;
  localparam int HALF = BAUD / 2;
  localparam int CW   = $clog2(BAUD);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_BAUD = CW'(BAUD - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t        state, state_n;
  logic          meta, rx_s, rx_d;
  logic [1:0]    settle;
  logic          armed;
  logic [CW-1:0] cnt;
  logic [3:0]    bitc;
  logic [7:0]    shift;
  logic          fall, sample, take, set_valid, set_ferr, cnt_clr;

  // The synchroniser resets high, so a line that is already low at reset
  // release would look like a falling edge; start detection is only armed
  // once a genuine high sample has passed through the synchroniser.
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta   <= 1'b1;
      rx_s   <= 1'b1;
      rx_d   <= 1'b1;
      settle <= 2'b00;
      armed  <= 1'b0;
    end else begin
      meta   <= rx;
      rx_s   <= meta;
      rx_d   <= rx_s;
      settle <= {settle[0], 1'b1};
      if (settle[1] && rx_s) armed <= 1'b1;
    end
  end

  assign fall = armed && rx_d && !rx_s;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (fall) state_n = START;
      START:   if (cnt == CNT_HALF) state_n = rx_s ? IDLE : DATA;
      DATA:    if (cnt == CNT_BAUD && bitc == 4'd7) state_n = STOP;
      STOP:    if (cnt == CNT_BAUD) state_n = rx_s ? IDLE : BRK;
      BRK:     if (rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    sample    = (state == DATA) && (cnt == CNT_BAUD);
    take      = (state == STOP) && (cnt == CNT_BAUD);
    set_valid = take && rx_s;
    set_ferr  = take && !rx_s;
    cnt_clr   = (state == IDLE) || (state == BRK) || (state_n != state) || sample;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt         <= '0;
      bitc        <= 4'd0;
      shift       <= 8'h00;
      data        <= 8'h00;
      valid       <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      cnt         <= cnt_clr ? '0 : cnt + 1'b1;
      valid       <= set_valid;
      frame_error <= set_ferr;
      if (state == START) bitc <= 4'd0;
      if (sample) begin
        shift <= {rx_s, shift[7:1]};
        bitc  <= bitc + 4'd1;
      end
      if (set_valid) data <= shift;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed and random 8N1 frames at BAUD=104 against a
// queue of expected outcomes, plus a 256-byte loopback run at BAUD=16.
module tb_uart_rx;
  localparam int B    = 104;
  localparam int H    = 52;
  localparam int B2   = 16;

  logic       clk = 1'b0;
  logic       reset, rst2;
  logic       rx, rx2;
  logic [7:0] data, data2;
  logic       valid, valid2, frame_error, frame_error2, busy, busy2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_rx dut (
    .clk(clk), .reset(reset), .rx(rx),
    .data(data), .valid(valid), .frame_error(frame_error), .busy(busy)
  );

  uart_rx #(.clockRate(1843200), .baudRate(115200)) dut_lb (
    .clk(clk), .reset(rst2), .rx(rx2),
    .data(data2), .valid(valid2), .frame_error(frame_error2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: each frame sent yields exactly one outcome, decided only by its
  // stop bit: bit 8 set = frame error (data must hold), clear = valid with byte.
  logic [8:0] exp_q[$];
  logic [8:0] e;
  logic [7:0] last_good = 8'h00;
  logic       prev_busy = 1'b0;

  always @(negedge clk) begin
    if (!reset) last_good = 8'h00;
    if (valid && frame_error) chk("both_pulses", 32'(1), 32'(0));
    if (valid || frame_error) begin
      if (exp_q.size() == 0) chk("unexpected_pulse", 32'({valid, frame_error}), 32'(0));
      else begin
        e = exp_q.pop_front();
        chk("pulse_kind", 32'(frame_error), 32'(e[8]));
        if (valid) begin
          chk("data", 32'(data), 32'(e[7:0]));
          chk("busy_fall", 32'({prev_busy, busy}), 32'(2'b10));
          last_good = e[7:0];
        end else begin
          chk("data_hold", 32'(data), 32'(last_good));
        end
      end
    end
    prev_busy = busy;
  end

  task automatic send_frame(input logic [7:0] b, input logic stop);
    exp_q.push_back({~stop, b});
    rx = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (B) @(negedge clk);
    end
    rx = stop;
    repeat (B) @(negedge clk);
  endtask

  int lb_cnt = 0;
  logic [7:0] lb_exp = 8'h00;

  always @(negedge clk) begin
    if (frame_error2) chk("lb_ferr", 32'(1), 32'(0));
    if (valid2) begin
      chk("lb_data", 32'(data2), 32'(lb_exp));
      lb_exp = lb_exp + 8'd1;
      lb_cnt++;
    end
  end

  int n;
  logic [7:0] rb;
  logic rs;

  initial begin
    reset = 1'b0; rst2 = 1'b0; rx = 1'b1; rx2 = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_data", 32'(data), 32'(0));
    chk("rst_valid", 32'(valid), 32'(0));
    chk("rst_ferr", 32'(frame_error), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    reset = 1'b1; rst2 = 1'b1;
    repeat (10) @(negedge clk);

    fork
      begin
        // transmitter model: next frame starts the cycle the previous ends
        for (int v = 0; v < 256; v++) begin
          rx2 = 1'b0;
          repeat (B2) @(negedge clk);
          for (int i = 0; i < 8; i++) begin
            rx2 = v[i];
            repeat (B2) @(negedge clk);
          end
          rx2 = 1'b1;
          repeat (B2) @(negedge clk);
        end
        repeat (4 * B2) @(negedge clk);
        chk("lb_count", 32'(lb_cnt), 32'(256));
      end
      begin
        send_frame(8'h55, 1'b1);
        repeat (20) @(negedge clk);

        send_frame(8'hA3, 1'b1);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (20) @(negedge clk);

        n = 0;
        rx = 1'b0;
        for (int i = 0; i < 150; i++) begin
          if (i == 30) rx = 1'b1;
          @(negedge clk);
          n += int'(busy);
        end
        chk("glitch_busy", 32'(n), 32'(H));
        send_frame(8'h3C, 1'b1);
        repeat (20) @(negedge clk);

        send_frame(8'h12, 1'b1);
        send_frame(8'h7E, 1'b0);
        n = 0;
        repeat (20 * B) begin
          @(negedge clk);
          n += int'(valid || frame_error);
        end
        chk("break_quiet", 32'(n), 32'(0));
        rx = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h81, 1'b1);
        repeat (20) @(negedge clk);

        // reset in the middle of data bit 4 of a frame that is never finished
        rb = 8'hE7;
        rx = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
          rx = rb[i];
          repeat (B) @(negedge clk);
        end
        rx = rb[4];
        repeat (B / 2) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'(1));
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_data", 32'(data), 32'(0));
        chk("midrst_valid", 32'(valid), 32'(0));
        chk("midrst_busy", 32'(busy), 32'(0));
        repeat (3) @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        n = 0;
        repeat (300) begin
          @(negedge clk);
          n += int'(busy || valid || frame_error);
        end
        chk("low_release_idle", 32'(n), 32'(0));
        rx = 1'b1;
        repeat (10) @(negedge clk);
        send_frame(8'h5A, 1'b1);

        for (int k = 0; k < 20; k++) begin
          rb = 8'($urandom);
          rs = ($urandom_range(0, 9) != 0);
          send_frame(rb, rs);
          rx = 1'b1;
          repeat (rs ? $urandom_range(0, 40) : $urandom_range(4, 40)) @(negedge clk);
        end
        repeat (2 * B) @(negedge clk);
      end
    join

    chk("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
